// File: rtl/aes_inv_key_schedule.sv
// -----------------------------------------------------------------------------
// aes_inv_key_schedule
//
// Sequential AES-128 key schedule for the decrypt datapath. A cipher key is
// expanded forward one round per clock up to the round-10 key. The schedule is
// then walked backwards, and round keys 10, 9, ... 0 are emitted one per
// handshake on a valid/ready stream. A single SubWord(RotWord())^Rcon word
// path is shared by the forward and the inverse step.
//
// Optional build macro: AES_INVKS_DIRECT_LOAD_EN
//   When defined, load_final/final_key let a cached round-10 key be loaded
//   straight into the emit phase, so the forward expansion is skipped.
//
// Ports:
//   clk         in   1    system clock, rising edge
//   rst_n       in   1    asynchronous active-low reset
//   start       in   1    begin a schedule (sampled only in IDLE)
//   cipher_key  in   128  AES-128 key, captured on the accepted start edge
//   busy        out  1    high whenever the FSM is not IDLE
//   rk_valid    out  1    rk_data/rk_round hold a valid round key
//   rk_ready    in   1    consumer accepts the key when rk_valid & rk_ready
//   rk_data     out  128  round key, word w[4r] in bits [127:96]
//   rk_round    out  4    round index of rk_data (10 down to 0)
//   done        out  1    one-cycle pulse after round key 0 is accepted
//   load_final  in   1    (macro only) load final_key as the round-10 key
//   final_key   in   128  (macro only) cached round-10 key
//
// Stream handshake: a key transfers on every rising edge where rk_valid and
// rk_ready are both high. While rk_valid is high and rk_ready is low, rk_data
// and rk_round hold steady. rk_valid is a register and never depends
// combinationally on rk_ready. rk_data is stale outside rk_valid.
// -----------------------------------------------------------------------------
module aes_inv_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] cipher_key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         done
`ifdef AES_INVKS_DIRECT_LOAD_EN
    ,
    input  logic         load_final,
    input  logic [127:0] final_key
`endif
);

    generate
        if (NR != 10) begin : g_bad_nr
            $error("aes_inv_key_schedule: only NR=10 (AES-128) is supported");
        end
    endgenerate

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // AES S-box, entry 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] i);
        logic [7:0] rc;
        case (i)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h0};
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     round_q, round_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] n4, n5, n6, n7;
    logic [31:0] sbox_in;
    logic [3:0]  rcon_idx;
    logic [31:0] mix;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // The inverse step needs w[4r-1] = w3^w2 before it can recover w[4r-4],
    // so the shared S-box path is fed p3 while emitting and w3 while expanding.
    assign p3       = w3 ^ w2;
    assign p2       = w2 ^ w1;
    assign p1       = w1 ^ w0;
    assign sbox_in  = (state_q == EMIT) ? p3 : w3;
    assign rcon_idx = (state_q == EMIT) ? round_q : cnt_q;
    assign mix      = sub_word(rot_word(sbox_in)) ^ rcon(rcon_idx);
    assign p0       = w0 ^ mix;

    assign n4 = w0 ^ mix;
    assign n5 = w1 ^ n4;
    assign n6 = w2 ^ n5;
    assign n7 = w3 ^ n6;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef AES_INVKS_DIRECT_LOAD_EN
                if (load_final) begin
                    key_d   = final_key;
                    round_d = LAST_ROUND;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end else
`endif
                if (start) begin
                    key_d   = cipher_key;
                    cnt_d   = 4'd1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                key_d = {n4, n5, n6, n7};
                if (cnt_q == LAST_ROUND) begin
                    round_d = LAST_ROUND;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            EMIT: begin
                // valid_q is always high here, so rk_ready alone marks a transfer.
                if (rk_ready) begin
                    if (round_q != 4'd0) begin
                        key_d   = {p0, p1, p2, p3};
                        round_d = round_q - 4'd1;
                    end else begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign rk_valid = valid_q;
    assign rk_data  = key_q;
    assign rk_round = round_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_key_schedule
//
// Directed bench for aes_inv_key_schedule. Expected round keys are the
// FIPS-197 appendix A.1 expansion and the well-known all-zero-key expansion.
// -----------------------------------------------------------------------------
module tb_aes_inv_key_schedule;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] cipher_key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         done;
`ifdef AES_INVKS_DIRECT_LOAD_EN
    logic         load_final;
    logic [127:0] final_key;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_keys [0:10];
    bit           chk_en   [0:10];

    // backpressure bookkeeping
    int           bp_r;
    int           bp_cyc;
    logic         bp_rdy;
    logic         bp_hold;
    logic [127:0] bp_prev_data;
    logic [3:0]   bp_prev_round;

    aes_inv_key_schedule #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cipher_key (cipher_key),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_data    (rk_data),
        .rk_round   (rk_round),
        .done       (done)
`ifdef AES_INVKS_DIRECT_LOAD_EN
        ,
        .load_final (load_final),
        .final_key  (final_key)
`endif
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic load_fips();
        exp_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) chk_en[i] = 1'b1;
    endtask

    task automatic load_zero();
        for (int i = 0; i <= 10; i++) begin
            exp_keys[i] = '0;
            chk_en[i]   = 1'b0;
        end
        exp_keys[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        exp_keys[1]  = 128'h62636363626363636263636362636363;
        exp_keys[0]  = 128'h0;
        chk_en[10] = 1'b1;
        chk_en[1]  = 1'b1;
        chk_en[0]  = 1'b1;
    endtask

    // Start edge is edge 1; rk_valid must be low after edge 10 and high after
    // edge 11. A stray start can be injected before edge inject_edge+1.
    task automatic do_start(input string tag, input logic [127:0] key, input int inject_edge);
        cipher_key = key;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, 1);
        for (int k = 2; k <= 10; k++) begin
            if (k - 1 == inject_edge) begin
                start      = 1'b1;
                cipher_key = '0;
            end
            tick();
            start = 1'b0;
        end
        chk({tag, "_valid_low_edge10"}, rk_valid, 0);
        tick();
    endtask

    // Walk rounds 10..0 with rk_ready high; ends sampled on the done cycle.
    task automatic emit_seq(input string tag, input int start_round);
        for (int r = 10; r >= 0; r--) begin
            chk($sformatf("%s_valid_r%0d", tag, r), rk_valid, 1);
            chk($sformatf("%s_round_r%0d", tag, r), rk_round, r);
            if (chk_en[r]) chk($sformatf("%s_data_r%0d", tag, r), rk_data, exp_keys[r]);
            if (r == start_round) begin
                start      = 1'b1;
                cipher_key = '0;
            end
            tick();
            start = 1'b0;
        end
        chk({tag, "_valid_end"}, rk_valid, 0);
        chk({tag, "_done_pulse"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        cipher_key = '0;
        rk_ready   = 1'b1;
`ifdef AES_INVKS_DIRECT_LOAD_EN
        load_final = 1'b0;
        final_key  = '0;
`endif
        #1 rst_n = 1'b0;
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_valid", rk_valid, 0);
        chk("reset_data", rk_data, 0);
        chk("reset_round", rk_round, 0);
        chk("reset_done", done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // FIPS-197 key, no backpressure
        load_fips();
        do_start("s1", FIPS_KEY, 0);
        emit_seq("s1", -1);

        // zero key, started in the very cycle done is high
        load_zero();
        do_start("s2", 128'h0, 0);
        emit_seq("s2", -1);
        tick();
        chk("s2_done_one_cycle", done, 0);

        // random backpressure
        load_fips();
        do_start("s3", FIPS_KEY, 0);
        bp_r    = 10;
        bp_cyc  = 0;
        bp_hold = 1'b0;
        while (bp_r >= 0 && bp_cyc < 400) begin
            chk($sformatf("s3_valid_r%0d", bp_r), rk_valid, 1);
            chk($sformatf("s3_round_r%0d", bp_r), rk_round, bp_r);
            chk($sformatf("s3_data_r%0d", bp_r), rk_data, exp_keys[bp_r]);
            chk("s3_busy", busy, 1);
            if (bp_hold) begin
                chk("s3_hold_data", rk_data, bp_prev_data);
                chk("s3_hold_round", rk_round, bp_prev_round);
            end
            bp_rdy        = 1'($urandom_range(0, 1));
            rk_ready      = bp_rdy;
            bp_prev_data  = rk_data;
            bp_prev_round = rk_round;
            bp_hold       = !bp_rdy;
            tick();
            bp_cyc++;
            if (bp_rdy) bp_r--;
        end
        chk("s3_within_budget", 1'(bp_r < 0), 1);
        chk("s3_done_pulse", done, 1);
        chk("s3_valid_end", rk_valid, 0);
        rk_ready = 1'b1;
        tick();
        chk("s3_done_cleared", done, 0);

        // start while busy: in EXPAND at cnt=5 and in EMIT at r=6
        do_start("s4", FIPS_KEY, 5);
        emit_seq("s4", 6);
        tick();
        chk("s4_done_cleared", done, 0);
        repeat (15) tick();
        chk("s4_no_second_run_busy", busy, 0);
        chk("s4_no_second_run_valid", rk_valid, 0);

        // reset during EMIT at r=6
        do_start("s5", FIPS_KEY, 0);
        for (int r = 10; r >= 7; r--) begin
            chk($sformatf("s5_data_r%0d", r), rk_data, exp_keys[r]);
            tick();
        end
        chk("s5_round_before_reset", rk_round, 6);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_valid", rk_valid, 0);
        chk("s5_rst_data", rk_data, 0);
        chk("s5_rst_round", rk_round, 0);
        chk("s5_rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("s5_no_done", done, 0);
        chk("s5_idle", busy, 0);
        do_start("s5b", FIPS_KEY, 0);
        emit_seq("s5b", -1);
        tick();

`ifdef AES_INVKS_DIRECT_LOAD_EN
        // direct load of the cached round-10 key; it wins over a concurrent start
        final_key  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        load_final = 1'b1;
        start      = 1'b1;
        cipher_key = '0;
        tick();
        load_final = 1'b0;
        start      = 1'b0;
        emit_seq("s6", -1);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
Sequential AES-128 key schedule for the decrypt datapath. It takes the cipher key, expands it forward iteratively to the round-10 key, then walks the schedule backwards. It emits round keys 10, 9, … 0 one at a time on a valid/ready stream that feeds the inverse-cipher round engine. One S-box word path (existing subword/rotword/rcon modules) is shared by both directions.

Parameters:
NR, 10, number of AES rounds; only 10 is legal, any other value is an elaboration error.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a schedule; sampled only in IDLE
cipher_key  input  128  AES-128 key, captured on the accepted start edge
busy  output  1  high whenever state is not IDLE
rk_valid  output  1  rk_data/rk_round hold a valid round key
rk_ready  input  1  consumer accepts the key when rk_valid & rk_ready
rk_data  output  128  round key, word w[4r] in bits [127:96]
rk_round  output  4  round index r of rk_data (10 down to 0)
done  output  1  one-cycle pulse after round key 0 is accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE, key register 0, round counter 0. busy=0, rk_valid=0, rk_data=0, rk_round=0, done=0.
- States: IDLE -> EXPAND -> EMIT -> IDLE.
- IDLE, start=1 at an edge: key_reg<=cipher_key, cnt<=1, go to EXPAND. start=0: stay. start is ignored in all other states; there is no queueing.
- EXPAND, one forward round per edge:
  - w4'=w0^SubWord(RotWord(w3))^Rcon(cnt), w5'=w1^w4', w6'=w2^w5', w7'=w3^w6'.
  - At cnt=10: go to EMIT with rk_round=10, rk_valid=1, else cnt++.
  - rk_valid is first high exactly 11 rising edges after the start edge.
- EMIT: rk_data=key_reg, rk_valid=1.
  - While rk_valid & !rk_ready, rk_data and rk_round stay stable.
  - On handshake with rk_round=r>0: key_reg <= inverse step for round r, rk_round<=r-1, rk_valid stays 1, giving back-to-back keys at 1 per cycle.
  - Inverse step: p3=w3^w2, p2=w2^w1, p1=w1^w0, p0=w0^SubWord(RotWord(p3))^Rcon(r).
  - On handshake with r=0: rk_valid<=0, done<=1 for one cycle, go to IDLE.
- Rcon(i) = {rc_i,24'h0}, rc = 01,02,04,08,10,20,40,80,1B,36.
- Stale data: rk_data holds the last value after EMIT ends. Consumers must qualify it with rk_valid.
- A new start is accepted in the same cycle done is high (state is IDLE then).
- rst_n asserted mid-EXPAND or mid-EMIT aborts at once to reset values; no done pulse.
- Registered outputs only. No combinational path from rk_ready to rk_valid.

Optional Feature:
AES_INVKS_DIRECT_LOAD_EN. When defined:
- Adds ports load_final (input 1) and final_key (input 128).
- load_final=1 in IDLE (priority over start) loads final_key as the round-10 key and enters EMIT directly, so rk_valid is high 1 edge later.
- Used when the round-10 key is cached from a prior encrypt.

When undefined: ports absent, only start/EXPAND path exists.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
   - rk_valid 11 edges after start.
   - Keys d014f9a8c9ee2589e13f0cc8b6630ca6 (r=10), ac7766f319fadc2128d12941575c006e (r=9), … a0fafe1788542cb123a339392a6c7605 (r=1), 2b7e1516…4f3c (r=0) on consecutive cycles.
   - done pulses once.
2. Zero key: r=10 key b4ef5bcb3e92e21123e951cf6f8f188e, r=1 key 62636363626363636263636362636363, r=0 all-zero.
3. Backpressure: randomly drop rk_ready ~50% -> rk_data/rk_round never change while valid&!ready; same 11-key sequence; busy stays high until done.
4. Assert start while busy, at EXPAND cnt=5 and during EMIT -> ignored; sequence unaffected; no second run.
5. Drop rst_n during EMIT at r=6 -> outputs immediately at reset values, no done. A new start then produces the full correct sequence.
6. With AES_INVKS_DIRECT_LOAD_EN: load_final with final_key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> rk_valid after 1 edge and the same descending sequence as scenario 1.
